// File: rtl/ysyx_22051013_pipe_ctrl.sv
// ysyx_22051013_pipe_ctrl: pipeline hold/flush control with stall counting
module ysyx_22051013_pipe_ctrl #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs1_addr,
  input  logic [4:0]             id_rs2_addr,
  input  logic                   id_rs1_ren,
  input  logic                   id_rs2_ren,
  input  logic [4:0]             ex_rd_addr,
  input  logic                   ex_rd_ena,
  input  logic                   ex_load_flag,
  input  logic                   ex_redirect,
  input  logic                   if_ready,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   md_start,
  input  logic                   md_done,
  output logic                   pc_hold,
  output logic                   ifid_hold,
  output logic                   ifid_flush,
  output logic                   idex_hold,
  output logic                   idex_flush,
  output logic                   exmem_hold,
  output logic                   memwb_bubble,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT, REDIR} state_t;
  state_t state, state_nx;
  logic mem_w, lu;
  assign mem_w = ~mem_ready & (mem_req | state == MEM_WAIT);
  assign lu = ex_load_flag & ex_rd_ena & (ex_rd_addr != 5'd0) &
              ((id_rs1_ren & id_rs1_addr == ex_rd_addr) | (id_rs2_ren & id_rs2_addr == ex_rd_addr));
  // Each state masks every lower-priority condition; memory wait masks all of them.
  always_comb begin
    pc_hold = 1'b0;
    ifid_hold = 1'b0;
    ifid_flush = 1'b0;
    idex_hold = 1'b0;
    idex_flush = 1'b0;
    exmem_hold = 1'b0;
    memwb_bubble = 1'b0;
    state_nx = state;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_w) begin
      {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_bubble} = 5'b11111;
      state_nx = state == RUN ? MEM_WAIT : state;
    end else if (state == MEM_WAIT) begin
      state_nx = RUN;
    end else if (state == MD_WAIT) begin
      {pc_hold, ifid_hold, idex_hold} = {3{~md_done}};
      state_nx = md_done ? RUN : MD_WAIT;
    end else if (state == REDIR) begin
      ifid_flush = ~if_ready | ex_redirect;
      idex_flush = ex_redirect;
      state_nx = if_ready ? RUN : REDIR;
    end else begin
      state_nx = md_start & ~md_done ? MD_WAIT : ex_redirect & ~if_ready ? REDIR : RUN;
      ifid_flush = ex_redirect | (~lu & ~if_ready);
      idex_flush = ex_redirect | lu;
      pc_hold = ~ex_redirect & (lu | ~if_ready);
      ifid_hold = ~ex_redirect & lu;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (pc_hold & ~&stall_cnt) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
// tb_ysyx_22051013_pipe_ctrl: directed and random checks against a behavioural model
module tb_ysyx_22051013_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_rs1_ren, id_rs2_ren, ex_rd_ena, ex_load_flag, ex_redirect, if_ready;
  logic mem_req, mem_ready, md_start, md_done;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble;
  logic [3:0] stall_cnt;
  logic [6:0] obs;
  int n = 0;
  int fails = 0;
  int m_mode;
  int m_cnt;

  ysyx_22051013_pipe_ctrl #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_rd_addr(ex_rd_addr), .ex_rd_ena(ex_rd_ena), .ex_load_flag(ex_load_flag),
    .ex_redirect(ex_redirect), .if_ready(if_ready),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .md_start(md_start), .md_done(md_done),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_flush(idex_flush), .exmem_hold(exmem_hold),
    .memwb_bubble(memwb_bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  assign obs = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble};

  // Modes: 0 run, 1 memory wait, 2 mul/div wait, 3 redirect refill.
  // Vector bits: pc_hold ifid_hold ifid_flush idex_hold idex_flush exmem_hold memwb_bubble.
  task automatic model(output logic [6:0] e, output int nm);
    bit lu;
    lu = ex_load_flag && ex_rd_ena && ex_rd_addr != 0 &&
         ((id_rs1_ren && id_rs1_addr == ex_rd_addr) || (id_rs2_ren && id_rs2_addr == ex_rd_addr));
    e = 7'b0000000;
    nm = m_mode;
    if (!mem_ready && (mem_req || m_mode == 1)) begin
      e = 7'b1101011;
      if (m_mode == 0) nm = 1;
    end else begin
      case (m_mode)
        1: nm = 0;
        2: if (md_done) nm = 0; else e = 7'b1101000;
        3: begin
          if (ex_redirect) e = 7'b0010100;
          else if (!if_ready) e = 7'b0010000;
          nm = if_ready ? 0 : 3;
        end
        default: begin
          if (ex_redirect) e = 7'b0010100;
          else if (lu) e = 7'b1100100;
          else if (!if_ready) e = 7'b1010000;
          if (md_start && !md_done) nm = 2;
          else if (ex_redirect && !if_ready) nm = 3;
          else nm = 0;
        end
      endcase
    end
  endtask

  task automatic step(input string tag);
    logic [6:0] e;
    int nm;
    #2;
    model(e, nm);
    n++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s outputs got=%b want=%b", tag, obs, e);
    end
    n++;
    assert (stall_cnt === 4'(m_cnt)) else begin
      fails++;
      $error("FAIL %s stall_cnt got=%0d want=%0d", tag, stall_cnt, m_cnt);
    end
    @(posedge clk);
    m_mode = nm;
    if (e[6] && m_cnt < 15) m_cnt++;
    #1;
  endtask

  task automatic idle();
    {id_rs1_addr, id_rs2_addr, ex_rd_addr} = '0;
    {id_rs1_ren, id_rs2_ren, ex_rd_ena, ex_load_flag, ex_redirect} = '0;
    {mem_req, mem_ready, md_start, md_done} = '0;
    if_ready = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    #1;
    n++;
    assert (obs === 7'b0010100) else begin
      fails++;
      $error("FAIL %s reset outputs got=%b want=%b", tag, obs, 7'b0010100);
    end
    n++;
    assert (stall_cnt === 4'd0) else begin
      fails++;
      $error("FAIL %s reset stall_cnt got=%0d want=0", tag, stall_cnt);
    end
    m_mode = 0;
    m_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    check_reset("por");
    idle(); step("idle");
    ex_load_flag = 1; ex_rd_ena = 1; ex_rd_addr = 5; id_rs1_ren = 1; id_rs1_addr = 5;
    step("loaduse");
    id_rs1_ren = 0; id_rs2_ren = 1; id_rs2_addr = 5; step("loaduse_rs2");
    ex_rd_addr = 0; id_rs2_addr = 0; step("x0_no_stall");
    idle(); mem_req = 1;
    repeat (3) step("memwait");
    mem_ready = 1; step("memdone");
    idle(); step("after_mem");
    md_start = 1; step("mdstart");
    md_start = 0;
    repeat (4) step("mdwait");
    md_done = 1; step("mddone");
    idle(); step("after_md");
    md_start = 1; md_done = 1; step("md_same_cycle");
    idle(); step("after_md_same");
    ex_redirect = 1; if_ready = 0; step("redirect");
    ex_redirect = 0;
    repeat (2) step("redir_wait");
    if_ready = 1; step("redir_done");
    idle(); mem_req = 1; ex_redirect = 1; step("redir_in_mem");
    ex_redirect = 0; step("mem_hold");
    mem_ready = 1; step("mem_release");
    idle(); md_start = 1; step("mdstart2");
    md_start = 0; ex_redirect = 1; step("redir_in_md");
    ex_redirect = 0; step("mdwait2");
    #2 rst = 1'b1;
    check_reset("rst_mid_md");
    idle(); step("after_rst");
    if_ready = 0;
    repeat (20) step("fetch_sat");
    idle();
    rst = 1'b1;
    check_reset("rst_sat");
    for (int i = 0; i < 400; i++) begin
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd_addr = 5'($urandom_range(0, 3));
      id_rs1_ren = 1'($urandom);
      id_rs2_ren = 1'($urandom);
      ex_rd_ena = 1'($urandom);
      ex_load_flag = 1'($urandom);
      ex_redirect = ($urandom % 6) == 0;
      if_ready = ($urandom % 4) != 0;
      mem_req = ($urandom % 4) == 0;
      mem_ready = 1'($urandom);
      md_start = ($urandom % 8) == 0;
      md_done = ($urandom % 3) == 0;
      step("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
